// File: rtl/bar_stream_fifo.sv
// rtl/bar_stream_fifo.sv - first-word fall-through valid/ready FIFO for the bar stream
// Optional occupancy output enabled by defining BAR_FIFO_LEVEL_EN.
module bar_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef BAR_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic full, empty, push, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  // in_ready depends only on registered state and rst, never on out_ready
  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; push is already blocked while rst is high
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef BAR_FIFO_LEVEL_EN
  assign level = count_q;
`endif

endmodule

// File: tb/tb_bar_stream_fifo.sv
// tb/tb_bar_stream_fifo.sv - self-checking bench for bar_stream_fifo against a queue model
// Level checks are compiled in when BAR_FIFO_LEVEL_EN is defined.
module tb_bar_stream_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef BAR_FIFO_LEVEL_EN
  logic [2:0]  level;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] mq[$];

  bar_stream_fifo #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef BAR_FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the queue model across the edge, return at edge+1.
  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic rs);
    bit m_push, m_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    rst       = rs;
    #2;
    m_push = v && !rs && (mq.size() < DEPTH);
    m_pop  = r && (mq.size() > 0);
    @(posedge clk);
    if (rs) mq.delete();
    else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
`ifdef BAR_FIFO_LEVEL_EN
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_single();
    drive(1'b1, 32'd42, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd42 || in_ready !== 1'b1)
      begin failures++; $display("FAIL single_push got v=%0b d=%0d r=%0b exp v=1 d=42 r=1", out_valid, out_data, in_ready); end
    drain();
  endtask

  task automatic test_fill_and_pop();
    for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
    drive(1'b1, 32'd5, 1'b0, 1'b0);
    checks++; if (out_data !== 32'd1 || in_ready !== 1'b0) begin failures++; $display("FAIL full_reject got d=%0d r=%0b exp d=1 r=0", out_data, in_ready); end
`ifdef BAR_FIFO_LEVEL_EN
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", level); end
`endif
    drive(1'b1, 32'd6, 1'b1, 1'b0);
    checks++; if (in_ready !== 1'b1 || out_data !== 32'd2) begin failures++; $display("FAIL full_pop got r=%0b d=%0d exp r=1 d=2", in_ready, out_data); end
    for (int e = 2; e <= 4; e++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 32'(e)) begin failures++; $display("FAIL full_drain_order got=%0d exp=%0d", out_data, e); end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'd0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd0) begin failures++; $display("FAIL stream_first got v=%0b d=%0d exp v=1 d=0", out_valid, out_data); end
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin failures++; $display("FAIL stream_word got v=%0b d=%0d exp v=1 d=%0d", out_valid, out_data, i); end
`ifdef BAR_FIFO_LEVEL_EN
      checks++; if (level !== 3'd1) begin failures++; $display("FAIL stream_level got=%0d exp=1", level); end
`endif
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_end got=%0b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive(1'b1, 32'(100 + i), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0)
      begin failures++; $display("FAIL midrst got v=%0b d=%0h r=%0b exp v=0 d=0 r=0", out_valid, out_data, in_ready); end
`ifdef BAR_FIFO_LEVEL_EN
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL midrst_level got=%0d exp=0", level); end
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_release got=%0b exp=1", in_ready); end
    drive(1'b1, 32'd7, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd7) begin failures++; $display("FAIL midrst_first got v=%0b d=%0d exp v=1 d=7", out_valid, out_data); end
    drain();
  endtask

  task automatic test_empty_no_bypass();
    in_valid = 1'b1; in_data = 32'd9; out_ready = 1'b1; rst = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin failures++; $display("FAIL empty_bypass got v=%0b d=%0d exp v=0 d=0", out_valid, out_data); end
    drive(1'b1, 32'd9, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd9) begin failures++; $display("FAIL empty_next got v=%0b d=%0d exp v=1 d=9", out_valid, out_data); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_popped got=%0b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] exp_d;
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 2));
      exp_d = (mq.size() > 0) ? mq[0] : 32'h0;
      checks++;
      if (out_valid !== (mq.size() > 0) || out_data !== exp_d ||
          in_ready !== ((mq.size() < DEPTH) && !rst))
        begin failures++; $display("FAIL random cyc=%0d got v=%0b d=%0h r=%0b exp v=%0b d=%0h r=%0b", n,
              out_valid, out_data, in_ready, mq.size() > 0, exp_d, (mq.size() < DEPTH) && !rst); end
`ifdef BAR_FIFO_LEVEL_EN
      checks++; if (level !== 3'(mq.size())) begin failures++; $display("FAIL random_level got=%0d exp=%0d", level, mq.size()); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_and_pop();
    test_back_to_back();
    test_reset_mid();
    test_empty_no_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
